// File: rtl/load_id_tracker_pkg.sv
// rtl/load_id_tracker_pkg.sv - shared types and helpers for the load ID tracker
// Purpose: per-entry state encoding, load size encoding, entry record and an
// offset alignment helper used by the tracker and its data extension unit.
// Ports: none (package).
package load_id_tracker_pkg;

  localparam int LD_TRANS_ID_W = 3;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_LIVE   = 2'd1,
    ST_KILLED = 2'd2
  } entry_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } ld_size_e;

  typedef struct packed {
    entry_state_e             state;
    logic [LD_TRANS_ID_W-1:0] trans_id;
    logic [2:0]               offset;
    ld_size_e                 size;
    logic                     is_signed;
  } ld_entry_t;

  // True when the byte offset is a multiple of the access size.
  function automatic logic offset_aligned(input logic [2:0] offset, input ld_size_e size);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return offset[0] == 1'b0;
      SZ_W:    return offset[1:0] == 2'b00;
      default: return offset == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ld_data_extend.sv
// rtl/ld_data_extend.sv - combinational load data align and sign/zero extend
// Purpose: shifts the raw 64-bit dcache word down to the accessed byte lane,
// keeps 8/16/32/64 bits according to size and extends to 64 bits.
// Ports:
//   offset    in  3   byte offset within the word
//   size      in  2   access size (B/H/W/D)
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   data      in  64  raw dcache word
//   result    out 64  aligned, extended load data
module ld_data_extend
  import load_id_tracker_pkg::*;
(
  input  logic [2:0]  offset,
  input  ld_size_e    size,
  input  logic        is_signed,
  input  logic [63:0] data,
  output logic [63:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (size)
      SZ_B:    result = {{56{is_signed & shifted[7]}},  shifted[7:0]};
      SZ_H:    result = {{48{is_signed & shifted[15]}}, shifted[15:0]};
      SZ_W:    result = {{32{is_signed & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_id_tracker.sv
// rtl/load_id_tracker.sv - outstanding load tracker between load unit and dcache
// Purpose: grants a small load ID per accepted request, remembers the
// scoreboard trans_id and access shape, matches dcache responses by ID and
// emits a registered, aligned and extended writeback result. A flush turns
// live entries into killed ones whose responses free the slot silently.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   flush_i                           kill all in-flight entries
//   req_valid_i/req_ready_o           load request handshake
//   req_trans_id_i/offset/size/signed request attributes
//   alloc_id_o                        ID granted to the accepted request
//   rsp_valid_i/rsp_id_i/rsp_data_i   dcache read response
//   res_valid_o/res_trans_id_o/res_data_o  writeback result (1 cycle after response)
//   busy_o                            any entry occupied
module load_id_tracker
  import load_id_tracker_pkg::*;
#(
  parameter int NR_ENTRIES = 2,
  parameter int TRANS_ID_W = LD_TRANS_ID_W,
  parameter int ID_W       = $clog2(NR_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [TRANS_ID_W-1:0] req_trans_id_i,
  input  logic [2:0]            req_offset_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  output logic [ID_W-1:0]       alloc_id_o,
  input  logic                  rsp_valid_i,
  input  logic [ID_W-1:0]       rsp_id_i,
  input  logic [63:0]           rsp_data_i,
  output logic                  res_valid_o,
  output logic [TRANS_ID_W-1:0] res_trans_id_o,
  output logic [63:0]           res_data_o,
  output logic                  busy_o
);

  ld_entry_t       entries [NR_ENTRIES];
  ld_entry_t       rsp_entry;
  logic            any_free;
  logic [ID_W-1:0] free_idx;
  logic            accept;
  logic            rsp_live;
  logic [63:0]     ext_data;

  // Lowest-index free slot: scan downwards so the last hit is the lowest.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    busy_o   = 1'b0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].state == ST_FREE) begin
        any_free = 1'b1;
        free_idx = ID_W'(i);
      end else begin
        busy_o = 1'b1;
      end
    end
  end

  assign req_ready_o = any_free & ~flush_i;
  assign alloc_id_o  = free_idx;
  assign accept      = req_valid_i & req_ready_o;

  assign rsp_entry = entries[rsp_id_i];
  // A flush in the response cycle kills the entry, so no result is produced.
  assign rsp_live  = rsp_valid_i & (rsp_entry.state == ST_LIVE) & ~flush_i;

  ld_data_extend u_extend (
    .offset    (rsp_entry.offset),
    .size      (rsp_entry.size),
    .is_signed (rsp_entry.is_signed),
    .data      (rsp_data_i),
    .result    (ext_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      res_valid_o    <= 1'b0;
      res_trans_id_o <= '0;
      res_data_o     <= '0;
    end else begin
      res_valid_o <= rsp_live;
      if (rsp_live) begin
        res_trans_id_o <= TRANS_ID_W'(rsp_entry.trans_id);
        res_data_o     <= ext_data;
      end
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (flush_i && entries[i].state == ST_LIVE) begin
          entries[i].state <= ST_KILLED;
        end
        // Responses to free slots are illegal and leave state untouched.
        if (rsp_valid_i && rsp_id_i == ID_W'(i) && entries[i].state != ST_FREE) begin
          entries[i].state <= ST_FREE;
        end
        // Accept only targets a free slot, so it never collides with the above.
        if (accept && free_idx == ID_W'(i)) begin
          entries[i].state     <= ST_LIVE;
          entries[i].trans_id  <= LD_TRANS_ID_W'(req_trans_id_i);
          entries[i].offset    <= req_offset_i;
          entries[i].size      <= ld_size_e'(req_size_i);
          entries[i].is_signed <= req_signed_i;
        end
      end
    end
  end

  a_rsp_not_free: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> (rsp_entry.state != ST_FREE));

  a_offset_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    accept |-> offset_aligned(req_offset_i, ld_size_e'(req_size_i)));

endmodule

// File: tb/tb_load_id_tracker.sv
// tb/tb_load_id_tracker.sv - self-checking bench for load_id_tracker
module tb_load_id_tracker;

  localparam int NR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_trans_id;
  logic [2:0]  req_offset;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [0:0]  alloc_id;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        res_valid;
  logic [2:0]  res_trans_id;
  logic [63:0] res_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = free, 1 = live, 2 = killed
  int   m_state [NR];
  int   m_tid   [NR];
  int   m_off   [NR];
  int   m_sz    [NR];
  bit   m_sgn   [NR];

  always #5 clk = ~clk;

  load_id_tracker dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_trans_id_i (req_trans_id),
    .req_offset_i   (req_offset),
    .req_size_i     (req_size),
    .req_signed_i   (req_signed),
    .alloc_id_o     (alloc_id),
    .rsp_valid_i    (rsp_valid),
    .rsp_id_i       (rsp_id),
    .rsp_data_i     (rsp_data),
    .res_valid_o    (res_valid),
    .res_trans_id_o (res_trans_id),
    .res_data_o     (res_data),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic model of the load result: pick the byte lane, mask to the
  // access width, then fill the upper bits if the sign bit is set.
  function automatic logic [63:0] ref_extend(input logic [63:0] d, input int off,
                                             input int sz, input bit sg);
    int          bits;
    logic [63:0] v;
    logic [63:0] mask;
    bits = 8 << sz;
    v    = d >> (off * 8);
    mask = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    v    = v & mask;
    if (sg && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < NR; i++) if (m_state[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rq, input int tid, input int off, input int sz, input bit sg,
                      input bit rv, input int rid, input logic [63:0] rd, input bit fl);
    int          lowest;
    bit          accept;
    bit          exp_rv;
    int          exp_tid;
    logic [63:0] exp_data;
    lowest       = -1;
    exp_tid      = 0;
    exp_data     = '0;
    req_valid    = rq;
    req_trans_id = 3'(tid);
    req_offset   = 3'(off);
    req_size     = 2'(sz);
    req_signed   = sg;
    rsp_valid    = rv;
    rsp_id       = 1'(rid);
    rsp_data     = rd;
    flush        = fl;
    #1;
    for (int i = NR - 1; i >= 0; i--) if (m_state[i] == 0) lowest = i;
    check("req_ready", 64'(req_ready), 64'((lowest >= 0) && !fl));
    if (lowest >= 0 && !fl) check("alloc_id", 64'(alloc_id), 64'(lowest));
    accept = rq && (lowest >= 0) && !fl;
    exp_rv = rv && (m_state[rid] == 1) && !fl;
    if (exp_rv) begin
      exp_tid  = m_tid[rid];
      exp_data = ref_extend(rd, m_off[rid], m_sz[rid], m_sgn[rid]);
    end
    if (fl) for (int i = 0; i < NR; i++) if (m_state[i] == 1) m_state[i] = 2;
    if (rv) m_state[rid] = 0;
    if (accept) begin
      m_state[lowest] = 1;
      m_tid[lowest]   = tid;
      m_off[lowest]   = off;
      m_sz[lowest]    = sz;
      m_sgn[lowest]   = sg;
    end
    @(posedge clk);
    #1;
    check("res_valid", 64'(res_valid), 64'(exp_rv));
    if (exp_rv) begin
      check("res_trans_id", 64'(res_trans_id), 64'(exp_tid));
      check("res_data", res_data, exp_data);
    end
    check("busy", 64'(busy), 64'(model_busy()));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 64'd0, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m_state[i] = 0;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_trans_id", 64'(res_trans_id), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
  endtask

  int          r_sz;
  int          r_off;
  int          r_rid;
  bit          r_rv;
  bit          r_fl;
  logic [63:0] r_data;
  int          occ [$];

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_trans_id = '0; req_offset = '0;
    req_size = '0; req_signed = 1'b0; rsp_valid = 1'b0; rsp_id = '0; rsp_data = '0;
    for (int i = 0; i < NR; i++) begin
      m_state[i] = 0; m_tid[i] = 0; m_off[i] = 0; m_sz[i] = 0; m_sgn[i] = 1'b0;
    end
    @(posedge clk);
    do_reset();

    // Signed byte load
    step(1, 5, 3, 0, 1, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 64'h0000_0000_8000_0000, 0);
    check("lb_data", res_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_trans_id", 64'(res_trans_id), 64'd5);

    // Fill both slots, then free ID1
    step(1, 1, 0, 3, 0, 0, 0, 64'd0, 0);
    step(1, 2, 0, 3, 0, 0, 0, 64'd0, 0);
    check("full_ready", 64'(req_ready), 64'd0);
    idle();
    step(0, 0, 0, 0, 0, 1, 1, 64'h1122_3344_5566_7788, 0);
    check("refill_ready", 64'(req_ready), 64'd1);
    check("refill_alloc", 64'(alloc_id), 64'd1);

    // Out-of-order completion
    step(1, 3, 0, 3, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 64'hA5A5_0000_1234_FFFF, 0);
    check("ooo_first_tid", 64'(res_trans_id), 64'd3);
    step(0, 0, 0, 0, 0, 1, 0, 64'h0102_0304_0506_0708, 0);
    check("ooo_second_tid", 64'(res_trans_id), 64'd1);
    check("ooo_busy", 64'(busy), 64'd0);

    // Flush kills both live entries
    step(1, 4, 2, 1, 1, 0, 0, 64'd0, 0);
    step(1, 5, 0, 2, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 64'd0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("killed0_no_result", 64'(res_valid), 64'd0);
    step(0, 0, 0, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("killed1_no_result", 64'(res_valid), 64'd0);
    check("flush_ready_back", 64'(req_ready), 64'd1);

    // Flush and response in the same cycle
    step(1, 6, 0, 3, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 1);
    check("flush_rsp_no_result", 64'(res_valid), 64'd0);
    check("flush_rsp_busy", 64'(busy), 64'd0);

    // Unsigned word at offset 4, then reset mid-flight
    step(1, 6, 4, 2, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 64'hF234_5678_0000_0000, 0);
    check("lwu_data", res_data, 64'h0000_0000_F234_5678);
    step(1, 2, 0, 0, 0, 0, 0, 64'd0, 0);
    step(1, 3, 6, 1, 1, 0, 0, 64'd0, 0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      occ.delete();
      for (int i = 0; i < NR; i++) if (m_state[i] != 0) occ.push_back(i);
      r_sz   = int'($urandom_range(3, 0));
      r_off  = int'($urandom_range(7, 0)) & ~((1 << r_sz) - 1);
      r_rv   = (occ.size() > 0) && ($urandom_range(1, 0) == 1);
      r_rid  = r_rv ? occ[$urandom_range(occ.size() - 1, 0)] : 0;
      r_data = {$urandom, $urandom};
      r_fl   = ($urandom_range(15, 0) == 0);
      step($urandom_range(1, 0) == 1, int'($urandom_range(7, 0)), r_off, r_sz,
           $urandom_range(1, 0) == 1, r_rv, r_rid, r_data, r_fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
